// File: rtl/stopwatch_bcd_multi_if.sv
// stopwatch_bcd_multi_if: control inputs and display/status outputs of the BCD stopwatch
interface stopwatch_bcd_multi_if #(parameter int NUM_DIGITS = 4);
    logic                    start_stop;
    logic                    lap;
    logic                    dir;
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_value;
    logic [4*NUM_DIGITS-1:0] bcd;
    logic [7*NUM_DIGITS-1:0] seg;
    logic                    running;
    logic                    lapped;
    logic                    done;
    logic                    wrap;
    modport master (output start_stop, lap, dir, load, load_value,
                    input  bcd, seg, running, lapped, done, wrap);
    modport slave  (input  start_stop, lap, dir, load, load_value,
                    output bcd, seg, running, lapped, done, wrap);
endinterface

// File: rtl/stopwatch_bcd_multi.sv
// stopwatch_bcd_multi: N-digit BCD up/down stopwatch with prescaler, preset load and lap freeze
module stopwatch_bcd_multi #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1000000
) (
    input logic clk,
    input logic reset,
    stopwatch_bcd_multi_if.slave sw
);
    localparam int W  = 4 * NUM_DIGITS;
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    typedef enum logic [1:0] {IDLE, RUN, LAP, LAP_STOP} state_t;
    state_t                  state;
    logic [W-1:0]            count, snapshot, inc_v, dec_v, ld_v;
    logic [PW-1:0]           presc;
    logic                    ss_q, lap_q, done_r, wrap_r;
    logic                    cy, bw, all9, active, tick, term, ss_edge, lap_edge, count_one;
    logic [7*NUM_DIGITS-1:0] seg_v;
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: seg7 = 7'b0111111;
            4'd1: seg7 = 7'b0000110;
            4'd2: seg7 = 7'b1011011;
            4'd3: seg7 = 7'b1001111;
            4'd4: seg7 = 7'b1100110;
            4'd5: seg7 = 7'b1101101;
            4'd6: seg7 = 7'b1111101;
            4'd7: seg7 = 7'b0000111;
            4'd8: seg7 = 7'b1111111;
            4'd9: seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction
    assign ss_edge   = sw.start_stop & ~ss_q;
    assign lap_edge  = sw.lap & ~lap_q;
    assign active    = (state == RUN) || (state == LAP);
    assign tick      = active && (presc == PW'(TICK_DIV - 1));
    assign count_one = (count == W'(1));
    assign term      = tick && sw.dir && count_one;
    // Ripple carry/borrow across digits; the final carry flags the all-9s wrap.
    always_comb begin
        cy    = 1'b1;
        bw    = 1'b1;
        inc_v = '0;
        dec_v = '0;
        ld_v  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            inc_v[4*i+:4] = cy ? (count[4*i+:4] == 4'd9 ? 4'd0 : count[4*i+:4] + 4'd1) : count[4*i+:4];
            dec_v[4*i+:4] = bw ? (count[4*i+:4] == 4'd0 ? 4'd9 : count[4*i+:4] - 4'd1) : count[4*i+:4];
            ld_v[4*i+:4]  = sw.load_value[4*i+:4] > 4'd9 ? 4'd9 : sw.load_value[4*i+:4];
            cy = cy & (count[4*i+:4] == 4'd9);
            bw = bw & (count[4*i+:4] == 4'd0);
        end
        all9 = cy;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            count    <= '0;
            snapshot <= '0;
            presc    <= '0;
            ss_q     <= 1'b1;
            lap_q    <= 1'b1;
            done_r   <= 1'b0;
            wrap_r   <= 1'b0;
        end else begin
            ss_q   <= sw.start_stop;
            lap_q  <= sw.lap;
            done_r <= term;
            wrap_r <= tick && !sw.dir && all9;
            if (active) presc <= tick ? '0 : presc + PW'(1);
            if (tick && !sw.dir) count <= inc_v;
            if (tick && sw.dir && count != '0) count <= dec_v;
            case (state)
                IDLE:
                    if (ss_edge) state <= (sw.dir && count == '0) ? IDLE : RUN;
                    else if (sw.load) begin
                        count <= ld_v;
                        presc <= '0;
                    end
                RUN:
                    if (ss_edge || term) state <= IDLE;
                    else if (lap_edge) begin
                        state    <= LAP;
                        snapshot <= count;
                    end
                LAP:      state <= (ss_edge || term) ? LAP_STOP : lap_edge ? RUN : LAP;
                LAP_STOP: state <= ss_edge ? LAP : lap_edge ? IDLE : LAP_STOP;
                default:  state <= IDLE;
            endcase
        end
    end
    assign sw.bcd = (state == LAP || state == LAP_STOP) ? snapshot : count;
    always_comb begin
        seg_v = '0;
        for (int i = 0; i < NUM_DIGITS; i++) seg_v[7*i+:7] = seg7(sw.bcd[4*i+:4]);
    end
    assign sw.seg     = seg_v;
    assign sw.running = active;
    assign sw.lapped  = (state == LAP) || (state == LAP_STOP);
    assign sw.done    = done_r;
    assign sw.wrap    = wrap_r;
endmodule

// File: tb/tb_stopwatch_bcd_multi.sv
// tb_stopwatch_bcd_multi: cycle scoreboard against a decimal model plus directed test-plan checks
module tb_stopwatch_bcd_multi;
    localparam int N    = 2;
    localparam int DIV  = 4;
    localparam int MAXV = 99;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_err = 0;
    stopwatch_bcd_multi_if #(.NUM_DIGITS(N)) sw();
    stopwatch_bcd_multi #(.NUM_DIGITS(N), .TICK_DIV(DIV)) dut (.clk(clk), .reset(reset), .sw(sw));
    always #5 clk = ~clk;
    typedef struct {
        logic [4*N-1:0] bcd;
        logic [7*N-1:0] seg;
        logic           running, lapped, done, wrap;
    } exp_t;
    exp_t sb[$];
    logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask
    function automatic logic [4*N-1:0] to_bcd(input int v);
        logic [4*N-1:0] r;
        for (int i = 0; i < N; i++) begin
            r[4*i+:4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction
    function automatic logic [7*N-1:0] to_seg(input logic [4*N-1:0] b);
        logic [7*N-1:0] r;
        int d;
        for (int i = 0; i < N; i++) begin
            d = int'(b[4*i+:4]);
            r[7*i+:7] = segtab[d];
        end
        return r;
    endfunction
    // Model states: 0 idle, 1 run, 2 lap, 3 lap-stop; count kept as a plain integer.
    int   m_st, m_cnt, m_snap, m_pre, m_old, m_d;
    bit   m_ssq, m_lapq, m_done, m_wrap, sse, le, tk, trm, act;
    exp_t e_push, e_pop;
    always @(posedge clk) begin
        if (!reset) begin
            m_st = 0; m_cnt = 0; m_snap = 0; m_pre = 0;
            m_ssq = 1; m_lapq = 1; m_done = 0; m_wrap = 0;
        end else begin
            sse = sw.start_stop && !m_ssq;
            le  = sw.lap && !m_lapq;
            m_ssq = sw.start_stop;
            m_lapq = sw.lap;
            m_done = 0; m_wrap = 0; trm = 0; m_old = m_cnt;
            act = (m_st == 1 || m_st == 2);
            tk  = act && (m_pre == DIV - 1);
            if (act) m_pre = tk ? 0 : m_pre + 1;
            if (tk) begin
                if (!sw.dir) begin
                    m_cnt = (m_cnt + 1) % (MAXV + 1);
                    m_wrap = (m_cnt == 0);
                end else if (m_cnt > 0) begin
                    m_cnt = m_cnt - 1;
                    trm = (m_cnt == 0);
                    m_done = trm;
                end
            end
            if (m_st == 0) begin
                if (sse) m_st = (sw.dir && m_cnt == 0) ? 0 : 1;
                else if (sw.load) begin
                    m_cnt = 0;
                    for (int i = N - 1; i >= 0; i--) begin
                        m_d = int'(sw.load_value[4*i+:4]);
                        m_cnt = m_cnt * 10 + (m_d > 9 ? 9 : m_d);
                    end
                    m_pre = 0;
                end
            end else if (m_st == 1) begin
                if (sse || trm) m_st = 0;
                else if (le) begin m_st = 2; m_snap = m_old; end
            end else if (m_st == 2) begin
                if (sse || trm) m_st = 3;
                else if (le) m_st = 1;
            end else begin
                if (sse) m_st = 2;
                else if (le) m_st = 0;
            end
        end
        e_push.bcd     = to_bcd(m_st >= 2 ? m_snap : m_cnt);
        e_push.seg     = to_seg(e_push.bcd);
        e_push.running = (m_st == 1 || m_st == 2);
        e_push.lapped  = (m_st >= 2);
        e_push.done    = m_done;
        e_push.wrap    = m_wrap;
        sb.push_back(e_push);
    end
    always @(negedge clk) begin
        check("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) begin
            e_pop = sb.pop_front();
            check("sb_bcd", 32'(sw.bcd), 32'(e_pop.bcd));
            check("sb_seg", 32'(sw.seg), 32'(e_pop.seg));
            check("sb_running", 32'(sw.running), 32'(e_pop.running));
            check("sb_lapped", 32'(sw.lapped), 32'(e_pop.lapped));
            check("sb_done", 32'(sw.done), 32'(e_pop.done));
            check("sb_wrap", 32'(sw.wrap), 32'(e_pop.wrap));
        end
    end
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic press_ss();
        sw.start_stop = 1'b1;
        cyc(1);
        sw.start_stop = 1'b0;
    endtask
    task automatic press_lap();
        sw.lap = 1'b1;
        cyc(1);
        sw.lap = 1'b0;
    endtask
    task automatic do_load(input logic [4*N-1:0] v);
        sw.load = 1'b1;
        sw.load_value = v;
        cyc(1);
        sw.load = 1'b0;
    endtask
    initial begin
        reset = 1'b0;
        sw.start_stop = 1'b0; sw.lap = 1'b0; sw.dir = 1'b0; sw.load = 1'b0; sw.load_value = '0;
        cyc(3);
        check("rst_bcd", 32'(sw.bcd), 32'h00);
        check("rst_seg", 32'(sw.seg), 32'({7'b0111111, 7'b0111111}));
        check("rst_running", 32'(sw.running), 32'd0);
        reset = 1'b1;
        cyc(1);
        // up count
        press_ss();
        cyc(40);
        check("up_bcd", 32'(sw.bcd), 32'h10);
        check("up_seg", 32'(sw.seg), 32'({7'b0000110, 7'b0111111}));
        check("up_running", 32'(sw.running), 32'd1);
        press_ss();
        check("stop_running", 32'(sw.running), 32'd0);
        cyc(20);
        check("stop_hold", 32'(sw.bcd), 32'h10);
        // up wrap and load clamp
        do_load(8'h99);
        check("load99", 32'(sw.bcd), 32'h99);
        press_ss();
        cyc(3);
        check("prewrap_bcd", 32'(sw.bcd), 32'h99);
        check("prewrap_wrap", 32'(sw.wrap), 32'd0);
        cyc(1);
        check("wrap_bcd", 32'(sw.bcd), 32'h00);
        check("wrap_pulse", 32'(sw.wrap), 32'd1);
        check("wrap_running", 32'(sw.running), 32'd1);
        cyc(1);
        check("wrap_one_cycle", 32'(sw.wrap), 32'd0);
        press_ss();
        do_load(8'hC3);
        check("load_clamp", 32'(sw.bcd), 32'h93);
        // lap
        do_load(8'h00);
        press_ss();
        cyc(20);
        press_lap();
        check("lap_bcd", 32'(sw.bcd), 32'h05);
        check("lap_lapped", 32'(sw.lapped), 32'd1);
        cyc(20);
        check("lap_frozen", 32'(sw.bcd), 32'h05);
        press_lap();
        check("unlap_bcd", 32'(sw.bcd), 32'h10);
        check("unlap_lapped", 32'(sw.lapped), 32'd0);
        cyc(1);
        press_lap();
        check("lap2_bcd", 32'(sw.bcd), 32'h10);
        cyc(1);
        press_ss();
        check("lapstop_running", 32'(sw.running), 32'd0);
        check("lapstop_lapped", 32'(sw.lapped), 32'd1);
        cyc(1);
        press_lap();
        check("lapstop_idle_bcd", 32'(sw.bcd), 32'h11);
        check("lapstop_idle_lapped", 32'(sw.lapped), 32'd0);
        // count down
        sw.dir = 1'b1;
        do_load(8'h03);
        press_ss();
        cyc(11);
        check("down_pre_bcd", 32'(sw.bcd), 32'h01);
        check("down_pre_done", 32'(sw.done), 32'd0);
        cyc(1);
        check("down_bcd", 32'(sw.bcd), 32'h00);
        check("down_done", 32'(sw.done), 32'd1);
        check("down_running", 32'(sw.running), 32'd0);
        cyc(1);
        check("down_done_one_cycle", 32'(sw.done), 32'd0);
        press_ss();
        check("zero_no_start", 32'(sw.running), 32'd0);
        check("zero_no_done", 32'(sw.done), 32'd0);
        cyc(4);
        // reset mid-run with start_stop held high
        sw.dir = 1'b0;
        do_load(8'h35);
        press_ss();
        cyc(8);
        check("pre_reset_bcd", 32'(sw.bcd), 32'h37);
        sw.start_stop = 1'b1;
        reset = 1'b0;
        cyc(1);
        check("mid_rst_bcd", 32'(sw.bcd), 32'h00);
        check("mid_rst_seg", 32'(sw.seg), 32'({7'b0111111, 7'b0111111}));
        check("mid_rst_running", 32'(sw.running), 32'd0);
        cyc(2);
        reset = 1'b1;
        cyc(5);
        check("held_no_start", 32'(sw.running), 32'd0);
        sw.start_stop = 1'b0;
        cyc(1);
        press_ss();
        check("restart_running", 32'(sw.running), 32'd1);
        cyc(3);
        check("restart_bcd0", 32'(sw.bcd), 32'h00);
        cyc(1);
        check("restart_bcd1", 32'(sw.bcd), 32'h01);
        // priority, ignored load, partial tick across pause
        sw.start_stop = 1'b1;
        sw.lap = 1'b1;
        cyc(1);
        sw.start_stop = 1'b0;
        sw.lap = 1'b0;
        check("both_running", 32'(sw.running), 32'd0);
        check("both_lapped", 32'(sw.lapped), 32'd0);
        cyc(1);
        press_ss();
        do_load(8'h77);
        check("run_load_ignored", 32'(sw.bcd), 32'h01);
        cyc(2);
        check("run_step", 32'(sw.bcd), 32'h02);
        cyc(1);
        press_ss();
        cyc(3);
        check("pause_hold", 32'(sw.bcd), 32'h02);
        press_ss();
        check("resume_bcd", 32'(sw.bcd), 32'h02);
        cyc(1);
        check("resume_plus1", 32'(sw.bcd), 32'h02);
        cyc(1);
        check("resume_plus2", 32'(sw.bcd), 32'h03);
        cyc(2);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
